// File: rtl/thermal_ctrl_pkg.sv
// Shared state encodings and default limits
// for the thermal throttle controller.
package thermal_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'b00,
    ST_THROTTLE = 2'b01,
    ST_SHUTDOWN = 2'b10
  } therm_state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_TEMP_W  = 10;
  localparam int DEF_T_HOT   = 700;
  localparam int DEF_T_COOL  = 650;
  localparam int DEF_T_CRIT  = 850;
  localparam int DEF_WINDOW  = 16;
  localparam int DEF_BUDGET  = 4;

endpackage

// File: rtl/thermal_throttle_ctrl_if.sv
// Sensor, request and status bundle of the
// thermal throttle controller.
interface thermal_throttle_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int TEMP_W  = 10
);
  logic               temp_valid;
  logic [TEMP_W-1:0]  temp;
  logic               clear_crit;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         state;
  logic               throttle;
  logic               shutdown;

  modport master (
    output temp_valid, temp, clear_crit, req,
    input  grant, state, throttle, shutdown
  );

  modport slave (
    input  temp_valid, temp, clear_crit, req,
    output grant, state, throttle, shutdown
  );
endinterface

// File: rtl/thermal_throttle_ctrl_rr_arbiter.sv
// Round-robin arbiter with registered one-hot
// grant; the pointer moves only on a grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic               fire,
  output logic [NUM_REQ-1:0] grant
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic          found;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[(int'(ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        sel   = PW'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  assign fire = found && enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      grant <= '0;
    end else begin
      grant <= fire ? (NUM_REQ'(1) << sel) : '0;
      if (fire) begin
        ptr <= (sel == PW'(NUM_REQ - 1)) ? '0 : sel + PW'(1);
      end
    end
  end
endmodule

// File: rtl/thermal_throttle_ctrl.sv
// Temperature-driven NORMAL/THROTTLE/SHUTDOWN
// FSM gating a round-robin activity arbiter.
module thermal_throttle_ctrl
  import thermal_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int TEMP_W  = DEF_TEMP_W,
  parameter int T_HOT   = DEF_T_HOT,
  parameter int T_COOL  = DEF_T_COOL,
  parameter int T_CRIT  = DEF_T_CRIT,
  parameter int WINDOW  = DEF_WINDOW,
  parameter int BUDGET  = DEF_BUDGET
) (
  input logic clk,
  input logic rst_n,
  thermal_throttle_ctrl_if.slave bus
);
  localparam int WC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int BC_W = $clog2(BUDGET + 1);

  localparam logic [TEMP_W-1:0] HOT  = TEMP_W'(T_HOT);
  localparam logic [TEMP_W-1:0] COOL = TEMP_W'(T_COOL);
  localparam logic [TEMP_W-1:0] CRIT = TEMP_W'(T_CRIT);
  localparam logic [WC_W-1:0]   WLAST = WC_W'(WINDOW - 1);
  localparam logic [BC_W-1:0]   BMAX  = BC_W'(BUDGET);

  if (!(T_COOL < T_HOT && T_HOT < T_CRIT)) begin : g_bad_thr
    $error("thresholds must satisfy T_COOL < T_HOT < T_CRIT");
  end
  if (!(BUDGET >= 1 && BUDGET <= WINDOW)) begin : g_bad_bud
    $error("BUDGET must be within 1..WINDOW");
  end
  if (NUM_REQ < 2) begin : g_bad_req
    $error("NUM_REQ must be at least 2");
  end

  therm_state_e state_q, state_d;
  logic [WC_W-1:0] win_cnt;
  logic [BC_W-1:0] bud_cnt;
  logic            enable;
  logic            fire;
  logic            is_crit, is_hot, is_cool;

  assign is_crit = bus.temp >= CRIT;
  assign is_hot  = bus.temp >= HOT;
  assign is_cool = bus.temp < COOL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_NORMAL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.temp_valid) begin
      unique case (state_q)
        ST_NORMAL: begin
          if (is_crit)     state_d = ST_SHUTDOWN;
          else if (is_hot) state_d = ST_THROTTLE;
        end
        ST_THROTTLE: begin
          if (is_crit)      state_d = ST_SHUTDOWN;
          else if (is_cool) state_d = ST_NORMAL;
        end
        ST_SHUTDOWN: begin
          if (bus.clear_crit && is_cool) state_d = ST_NORMAL;
        end
        default: state_d = ST_NORMAL;
      endcase
    end
  end

  // Grant gating looks at the current state, never state_d.
  always_comb begin
    enable = 1'b0;
    unique case (state_q)
      ST_NORMAL:   enable = 1'b1;
      ST_THROTTLE: enable = bud_cnt < BMAX;
      default:     enable = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
      bud_cnt <= '0;
    end else if (state_q != ST_THROTTLE) begin
      win_cnt <= '0;
      bud_cnt <= '0;
    end else if (win_cnt == WLAST) begin
      win_cnt <= '0;
      bud_cnt <= BC_W'(fire);
    end else begin
      win_cnt <= win_cnt + WC_W'(1);
      bud_cnt <= bud_cnt + BC_W'(fire);
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (bus.req),
    .enable (enable),
    .fire   (fire),
    .grant  (bus.grant)
  );

  assign bus.state    = state_q;
  assign bus.throttle = state_q == ST_THROTTLE;
  assign bus.shutdown = state_q == ST_SHUTDOWN;
endmodule

// File: doc/thermal_throttle_ctrl.md
THERMAL_THROTTLE_CTRL -- requirements
Module: thermal_throttle_ctrl

Interface
REQ-001 Parameter NUM_REQ, 4, number of cell-bank activity requesters.
REQ-002 Parameter TEMP_W, 10, temperature sample width (unsigned).
REQ-003 Parameter T_HOT, 700, throttle-entry threshold.
REQ-004 Parameter T_COOL, 650, throttle/shutdown-exit threshold.
REQ-005 Parameter T_CRIT, 850, shutdown-entry threshold.
REQ-006 Parameter WINDOW, 16, throttle budget window length in cycles.
REQ-007 Parameter BUDGET, 4, maximum grants per window while throttled.
REQ-008 Port clk, input, 1, single clock; all state on rising edge.
REQ-009 Port rst_n, input, 1, reset, asynchronous, active-low.
REQ-010 Port temp_valid, input, 1, temp sample strobe.
REQ-011 Port temp, input, TEMP_W, sensor sample, qualified by temp_valid.
REQ-012 Port clear_crit, input, 1, operator request to leave SHUTDOWN.
REQ-013 Port req, input, NUM_REQ, per-bank activity request, level.
REQ-014 Port grant, output, NUM_REQ, registered one-hot-or-zero activity grant.
REQ-015 Port state, output, 2, FSM state: 00 NORMAL, 01 THROTTLE, 10 SHUTDOWN.
REQ-016 Port throttle, output, 1, high when state is THROTTLE.
REQ-017 Port shutdown, output, 1, high when state is SHUTDOWN.

Function
REQ-018 FSM transitions are evaluated only in cycles with temp_valid=1, using that cycle's temp, and take effect at the next edge.
REQ-019 Any state -> SHUTDOWN when temp >= T_CRIT; this has priority over every other transition.
REQ-020 NORMAL -> THROTTLE when T_HOT <= temp < T_CRIT.
REQ-021 THROTTLE -> NORMAL when temp < T_COOL; T_COOL <= temp < T_CRIT holds THROTTLE (hysteresis).
REQ-022 SHUTDOWN -> NORMAL only when clear_crit=1 in the same cycle as a temp_valid sample with temp < T_COOL; otherwise hold.
REQ-023 Grants: round-robin across req, at most one bit set, latency one cycle (req in cycle n -> grant in n+1).
REQ-024 Round-robin priority starts at the index after the last granted requester, wrapping NUM_REQ-1 -> 0.
REQ-025 A grant is held for a single cycle only; a continuously requesting bank re-arbitrates every cycle.
REQ-026 NORMAL: a grant is issued every cycle in which any req bit is high.
REQ-027 THROTTLE: win_cnt counts 0..WINDOW-1 and wraps; a grant is issued only while bud_cnt < BUDGET; bud_cnt increments per grant.
REQ-028 At win_cnt wrap, bud_cnt reloads to 1 if a grant is issued in that cycle, else 0.
REQ-029 On NORMAL -> THROTTLE entry, win_cnt and bud_cnt clear to 0.
REQ-030 SHUTDOWN: grant is 0 in every cycle starting the cycle after entry; the round-robin pointer is frozen.
REQ-031 A state change and a grant decision in the same cycle: the grant uses the pre-transition state.
REQ-032 Elaboration fails unless T_COOL < T_HOT < T_CRIT, 1 <= BUDGET <= WINDOW and NUM_REQ >= 2.

Reset
REQ-033 While rst_n=0: state=NORMAL, grant=0, throttle=0, shutdown=0, win_cnt=0, bud_cnt=0, pointer gives requester 0 first priority.
REQ-034 Reset asserted mid-window or mid-SHUTDOWN discards all history; no sticky critical flag survives reset.

Structure
REQ-035 Package thermal_ctrl_pkg holds the state encodings and default threshold/window constants.
REQ-036 Round-robin selection is one sub-module, rr_arbiter (NUM_REQ, req, enable, grant, pointer update).

Verification
REQ-037 req=4'b1111 in NORMAL for 8 cycles -> grants 0,1,2,3,0,1,2,3, first grant one cycle after req.
REQ-038 temp=720 strobed, req=4'b1111 for 32 cycles -> throttle=1; exactly 4 grants per 16-cycle window, 8 in total.
REQ-039 From THROTTLE, temp=660 -> stays THROTTLE; then temp=640 -> NORMAL; full-rate grants resume.
REQ-040 temp=860 strobed from NORMAL -> shutdown=1, grant=0; clear_crit=1 with temp=700 -> hold; clear_crit=1 with temp=600 -> NORMAL.
REQ-041 rst_n pulled low mid-THROTTLE with bud_cnt=3 -> all outputs 0 immediately; after release, first grant goes to requester 0.
REQ-042 req=4'b0100 only, THROTTLE, grant issued in wrap cycle -> new window allows 3 more grants.
